// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the branch resolution unit: entry layout helpers,
// the sequential-fetch increment and the mispredict cause encoding.
package branch_resolve_pkg;

  // Fall-through distance between sequential instructions.
  localparam int PC_INCR      = 4;
  localparam int PRED_TAKEN_W = 1;

  // Why an in-flight prediction was wrong.
  typedef enum logic [1:0] {
    MP_NONE  = 2'd0,
    MP_DIR   = 2'd1,  // branch direction wrong
    MP_TGT   = 2'd2,  // taken both ways, target wrong
    MP_ALIAS = 2'd3   // non-branch predicted taken
  } mp_cause_e;

  // In-flight entry is {pc, predicted taken, predicted target}.
  function automatic int entry_width(input int addr_w);
    return 2 * addr_w + PRED_TAKEN_W;
  endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// Fetch/execute/predictor-update bundle of the branch resolution unit.
// master = surrounding pipeline, slave = branch_resolve.
interface branch_resolve_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);
  logic                  fetch_valid;
  logic                  fetch_ready;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic                  predict_taken;
  logic [ADDR_WIDTH-1:0] predict_target_pc;
  logic                  ex_valid;
  logic                  ex_is_branch;
  logic                  ex_taken;
  logic [ADDR_WIDTH-1:0] ex_target_pc;
  logic [ADDR_WIDTH-1:0] ex_pc;
  logic                  flush;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  branch_ex;
  logic [ADDR_WIDTH-1:0] branch_pc_ex;
  logic                  branch_taken_ex;
  logic [ADDR_WIDTH-1:0] branch_target_pc;
  logic [CNT_WIDTH-1:0]  branch_cnt;
  logic [CNT_WIDTH-1:0]  mispredict_cnt;
  logic                  queue_err;

  modport master (
    output fetch_valid, fetch_pc, predict_taken, predict_target_pc,
           ex_valid, ex_is_branch, ex_taken, ex_target_pc, ex_pc,
    input  fetch_ready, flush, redirect_pc, branch_ex, branch_pc_ex,
           branch_taken_ex, branch_target_pc, branch_cnt, mispredict_cnt,
           queue_err
  );

  modport slave (
    input  fetch_valid, fetch_pc, predict_taken, predict_target_pc,
           ex_valid, ex_is_branch, ex_taken, ex_target_pc, ex_pc,
    output fetch_ready, flush, redirect_pc, branch_ex, branch_pc_ex,
           branch_taken_ex, branch_target_pc, branch_cnt, mispredict_cnt,
           queue_err
  );
endinterface

// File: rtl/branch_resolve_fifo.sv
// bp_inflight_fifo: synchronous FIFO holding fetch-time predictions until
// their instructions reach execute. Pointers carry an extra wrap bit so
// full and empty are distinguishable.
module bp_inflight_fifo #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 65
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [ENTRY_W-1:0]       push_data,
  input  logic                     pop,
  input  logic                     clear,
  output logic                     full,
  output logic                     empty,
  output logic [ENTRY_W-1:0]       head_data,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wptr;
  logic [PTR_W-1:0]   rptr;
  logic               push_en;
  logic               pop_en;

  assign push_en   = push && !full && !clear;
  assign pop_en    = pop && !empty && !clear;
  assign level     = wptr - rptr;
  assign full      = (level == PTR_W'(DEPTH));
  assign empty     = (wptr == rptr);
  assign head_data = mem[rptr[IDX_W-1:0]];

  // Pointer update; clear discards every in-flight entry at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_en) wptr <= wptr + PTR_W'(1);
      if (pop_en)  rptr <= rptr + PTR_W'(1);
    end
  end

  // Entry storage, written at the tail.
  always_ff @(posedge clk) begin
    if (push_en) mem[wptr[IDX_W-1:0]] <= push_data;
  end
endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: matches execute outcomes against queued fetch predictions,
// raises flush/redirect on a mispredict, drives predictor updates and keeps
// saturating branch/mispredict statistics.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 32
) (
  input logic          cpu_clk,
  input logic          cpu_rst,
  branch_resolve_if.slave bus
);
  localparam int ENTRY_W = entry_width(ADDR_WIDTH);
  localparam int PTR_W   = $clog2(DEPTH) + 1;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  logic [ENTRY_W-1:0]    push_entry;
  logic [ENTRY_W-1:0]    head_entry;
  logic [ADDR_WIDTH-1:0] head_pc;
  logic                  head_taken;
  logic [ADDR_WIDTH-1:0] head_target;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [PTR_W-1:0]      fifo_level;

  logic                  pop_req_p0;
  logic                  pop_ok_p0;
  logic                  pop_empty_p0;
  logic                  pc_mismatch_p0;
  logic                  push_ok_p0;
  logic                  update_p0;
  logic                  mispredict_p0;
  mp_cause_e             cause_p0;
  logic [ADDR_WIDTH-1:0] redirect_pc_p0;
  logic [PTR_W-1:0]      level_p0;
  logic                  fetch_ready_p0;

  logic                  fetch_ready_p1;
  logic                  flush_p1;
  logic [ADDR_WIDTH-1:0] redirect_pc_p1;
  logic                  branch_ex_p1;
  logic [ADDR_WIDTH-1:0] branch_pc_p1;
  logic                  branch_taken_p1;
  logic [ADDR_WIDTH-1:0] branch_target_p1;
  logic [CNT_WIDTH-1:0]  branch_cnt_p1;
  logic [CNT_WIDTH-1:0]  mispredict_cnt_p1;
  logic                  queue_err_p1;

  assign push_entry = {bus.fetch_pc, bus.predict_taken, bus.predict_target_pc};
  assign {head_pc, head_taken, head_target} = head_entry;

  bp_inflight_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_fifo (
    .clk       (cpu_clk),
    .rst       (cpu_rst),
    .push      (push_ok_p0),
    .push_data (push_entry),
    .pop       (pop_ok_p0),
    .clear     (mispredict_p0),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_data (head_entry),
    .level     (fifo_level)
  );

  // ---- stage p0: resolve the head entry against the execute outcome ----
  // The cycle after a mispredict (flush_p1) is a dead cycle: the retiring
  // instruction and any fetch are wrong-path and get ignored.
  assign pop_req_p0     = bus.ex_valid && !flush_p1;
  assign pop_ok_p0      = pop_req_p0 && !fifo_empty;
  assign pop_empty_p0   = pop_req_p0 && fifo_empty;
  assign pc_mismatch_p0 = pop_ok_p0 && (bus.ex_pc != head_pc);
  assign update_p0      = pop_ok_p0 && bus.ex_is_branch;

  // Mispredict classification and the correct next fetch address.
  always_comb begin
    cause_p0       = MP_NONE;
    redirect_pc_p0 = '0;
    if (pop_ok_p0) begin
      if (bus.ex_is_branch) begin
        if (bus.ex_taken != head_taken) begin
          cause_p0       = MP_DIR;
          redirect_pc_p0 = bus.ex_taken ? bus.ex_target_pc
                                        : head_pc + ADDR_WIDTH'(PC_INCR);
        end else if (bus.ex_taken && (bus.ex_target_pc != head_target)) begin
          cause_p0       = MP_TGT;
          redirect_pc_p0 = bus.ex_target_pc;
        end
      end else if (head_taken) begin
        cause_p0       = MP_ALIAS;
        redirect_pc_p0 = head_pc + ADDR_WIDTH'(PC_INCR);
      end
    end
  end

  assign mispredict_p0 = (cause_p0 != MP_NONE);
  // A push in the mispredict cycle is wrong-path and is dropped with the clear.
  assign push_ok_p0    = bus.fetch_valid && fetch_ready_p1 && !fifo_full &&
                         !flush_p1 && !mispredict_p0;

  // Next-state occupancy drives the registered ready, so a push can never
  // land on a full queue.
  always_comb begin
    level_p0 = fifo_level + PTR_W'(push_ok_p0) - PTR_W'(pop_ok_p0);
    if (mispredict_p0) level_p0 = '0;
  end
  assign fetch_ready_p0 = !mispredict_p0 && (level_p0 != PTR_W'(DEPTH));

  // ---- stage p1: registered outputs ----
  // Flush/redirect and fetch backpressure.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      fetch_ready_p1 <= 1'b1;
      flush_p1       <= 1'b0;
      redirect_pc_p1 <= '0;
    end else begin
      fetch_ready_p1 <= fetch_ready_p0;
      flush_p1       <= mispredict_p0;
      if (mispredict_p0) redirect_pc_p1 <= redirect_pc_p0;
    end
  end

  // Predictor update: one-cycle strobe, buses hold the last update.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      branch_ex_p1     <= 1'b0;
      branch_pc_p1     <= '0;
      branch_taken_p1  <= 1'b0;
      branch_target_p1 <= '0;
    end else begin
      branch_ex_p1 <= update_p0;
      if (update_p0) begin
        branch_pc_p1     <= head_pc;
        branch_taken_p1  <= bus.ex_taken;
        branch_target_p1 <= bus.ex_target_pc;
      end
    end
  end

  // Saturating statistics and the sticky queue error flag.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      branch_cnt_p1     <= '0;
      mispredict_cnt_p1 <= '0;
      queue_err_p1      <= 1'b0;
    end else begin
      if (update_p0)     branch_cnt_p1     <= sat_inc(branch_cnt_p1);
      if (mispredict_p0) mispredict_cnt_p1 <= sat_inc(mispredict_cnt_p1);
      if (pop_empty_p0 || pc_mismatch_p0) queue_err_p1 <= 1'b1;
    end
  end

  assign bus.fetch_ready      = fetch_ready_p1;
  assign bus.flush            = flush_p1;
  assign bus.redirect_pc      = redirect_pc_p1;
  assign bus.branch_ex        = branch_ex_p1;
  assign bus.branch_pc_ex     = branch_pc_p1;
  assign bus.branch_taken_ex  = branch_taken_p1;
  assign bus.branch_target_pc = branch_target_p1;
  assign bus.branch_cnt       = branch_cnt_p1;
  assign bus.mispredict_cnt   = mispredict_cnt_p1;
  assign bus.queue_err        = queue_err_p1;
endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve (DEPTH=4, 4-bit counters so that
// saturation is reachable in a short run).
module tb_branch_resolve;
  logic cpu_clk;
  logic cpu_rst;

  int n_pass  = 0;
  int n_total = 0;

  branch_resolve_if #(.ADDR_WIDTH(32), .CNT_WIDTH(4)) bus ();

  branch_resolve #(.ADDR_WIDTH(32), .DEPTH(4), .CNT_WIDTH(4)) dut (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .bus     (bus)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    logic        fv;   logic [31:0] fpc; logic pt;  logic [31:0] ptgt;
    logic        exv;  logic isb; logic tk; logic [31:0] tgt; logic [31:0] expc;
    logic        rdy;  logic fl;  logic [31:0] rpc;
    logic        bex;  logic [31:0] bpc; logic btk; logic [31:0] btgt;
    logic [3:0]  bcnt; logic [3:0] mcnt; logic err;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic fv, input logic [31:0] fpc, input logic pt,
                       input logic [31:0] ptgt, input logic exv, input logic isb,
                       input logic tk, input logic [31:0] tgt, input logic [31:0] expc);
    bus.fetch_valid       = fv;
    bus.fetch_pc          = fpc;
    bus.predict_taken     = pt;
    bus.predict_target_pc = ptgt;
    bus.ex_valid          = exv;
    bus.ex_is_branch      = isb;
    bus.ex_taken          = tk;
    bus.ex_target_pc      = tgt;
    bus.ex_pc             = expc;
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic push(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt);
    drive(1'b1, pc, pt, ptgt, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic pop(input logic isb, input logic tk, input logic [31:0] tgt,
                     input logic [31:0] expc);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, isb, tk, tgt, expc);
    tick();
  endtask

  task automatic chk_row(input int i);
    chk($sformatf("v%0d.fetch_ready", i), {31'b0, bus.fetch_ready}, {31'b0, vecs[i].rdy});
    chk($sformatf("v%0d.flush", i), {31'b0, bus.flush}, {31'b0, vecs[i].fl});
    chk($sformatf("v%0d.redirect_pc", i), bus.redirect_pc, vecs[i].rpc);
    chk($sformatf("v%0d.branch_ex", i), {31'b0, bus.branch_ex}, {31'b0, vecs[i].bex});
    chk($sformatf("v%0d.branch_pc_ex", i), bus.branch_pc_ex, vecs[i].bpc);
    chk($sformatf("v%0d.branch_taken_ex", i), {31'b0, bus.branch_taken_ex}, {31'b0, vecs[i].btk});
    chk($sformatf("v%0d.branch_target_pc", i), bus.branch_target_pc, vecs[i].btgt);
    chk($sformatf("v%0d.branch_cnt", i), {28'b0, bus.branch_cnt}, {28'b0, vecs[i].bcnt});
    chk($sformatf("v%0d.mispredict_cnt", i), {28'b0, bus.mispredict_cnt}, {28'b0, vecs[i].mcnt});
    chk($sformatf("v%0d.queue_err", i), {31'b0, bus.queue_err}, {31'b0, vecs[i].err});
  endtask

  initial begin
    logic [3:0] mexp;
    logic [31:0] p;

    // fv fpc pt ptgt | exv isb tk tgt expc | rdy fl rpc | bex bpc btk btgt | bcnt mcnt err
    vecs[0]  = '{1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   32'h0,
                 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   4'd0, 4'd0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h0,   32'h100,
                 1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0,   4'd1, 4'd0, 1'b0};
    vecs[2]  = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   32'h0,
                 1'b1, 1'b0, 32'h0,   1'b0, 32'h100, 1'b0, 32'h0,   4'd1, 4'd0, 1'b0};
    vecs[3]  = '{1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,
                 1'b1, 1'b0, 32'h0,   1'b0, 32'h100, 1'b0, 32'h0,   4'd1, 4'd0, 1'b0};
    // target mispredict; the simultaneous push of 0x2A0 must be dropped
    vecs[4]  = '{1'b1, 32'h2A0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h340, 32'h200,
                 1'b0, 1'b1, 32'h340, 1'b1, 32'h200, 1'b1, 32'h340, 4'd2, 4'd1, 1'b0};
    vecs[5]  = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   32'h0,
                 1'b1, 1'b0, 32'h340, 1'b0, 32'h200, 1'b1, 32'h340, 4'd2, 4'd1, 1'b0};
    vecs[6]  = '{1'b1, 32'h400, 1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,
                 1'b1, 1'b0, 32'h340, 1'b0, 32'h200, 1'b1, 32'h340, 4'd2, 4'd1, 1'b0};
    // aliasing non-branch predicted taken
    vecs[7]  = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h0,   32'h400,
                 1'b0, 1'b1, 32'h404, 1'b0, 32'h200, 1'b1, 32'h340, 4'd2, 4'd2, 1'b0};
    // flush cycle: push and ex_valid both ignored
    vecs[8]  = '{1'b1, 32'h900, 1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h0,   32'h900,
                 1'b1, 1'b0, 32'h404, 1'b0, 32'h200, 1'b1, 32'h340, 4'd2, 4'd2, 1'b0};
    // pop on empty
    vecs[9]  = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h0,   32'h900,
                 1'b1, 1'b0, 32'h404, 1'b0, 32'h200, 1'b1, 32'h340, 4'd2, 4'd2, 1'b1};
    vecs[10] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   32'h0,
                 1'b1, 1'b0, 32'h404, 1'b0, 32'h200, 1'b1, 32'h340, 4'd2, 4'd2, 1'b1};

    // Reset values
    cpu_rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge cpu_clk);
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
    tick();
    chk("rst.fetch_ready", {31'b0, bus.fetch_ready}, 32'h1);
    chk("rst.flush", {31'b0, bus.flush}, 32'h0);
    chk("rst.redirect_pc", bus.redirect_pc, 32'h0);
    chk("rst.branch_ex", {31'b0, bus.branch_ex}, 32'h0);
    chk("rst.branch_pc_ex", bus.branch_pc_ex, 32'h0);
    chk("rst.branch_target_pc", bus.branch_target_pc, 32'h0);
    chk("rst.branch_cnt", {28'b0, bus.branch_cnt}, 32'h0);
    chk("rst.mispredict_cnt", {28'b0, bus.mispredict_cnt}, 32'h0);
    chk("rst.queue_err", {31'b0, bus.queue_err}, 32'h0);

    // Table-driven single-cycle vectors
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].fv, vecs[i].fpc, vecs[i].pt, vecs[i].ptgt, vecs[i].exv,
            vecs[i].isb, vecs[i].tk, vecs[i].tgt, vecs[i].expc);
      tick();
      chk_row(i);
    end

    // Reset asserted during a flush cycle clears outputs immediately
    push(32'h600, 1'b1, 32'h700);
    pop(1'b1, 1'b0, 32'h0, 32'h600);
    chk("midrst.flush_before", {31'b0, bus.flush}, 32'h1);
    chk("midrst.redirect_before", bus.redirect_pc, 32'h604);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cpu_rst = 1'b1;
    #1;
    chk("midrst.flush", {31'b0, bus.flush}, 32'h0);
    chk("midrst.queue_err", {31'b0, bus.queue_err}, 32'h0);
    chk("midrst.branch_cnt", {28'b0, bus.branch_cnt}, 32'h0);
    chk("midrst.redirect_pc", bus.redirect_pc, 32'h0);
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
    tick();

    // Fill to DEPTH
    for (int k = 0; k < 4; k++) begin
      push(32'h1000 + 32'(4 * k), 1'b0, 32'h0);
      chk($sformatf("fill%0d.fetch_ready", k), {31'b0, bus.fetch_ready}, (k < 3) ? 32'h1 : 32'h0);
    end
    push(32'hDEAD, 1'b0, 32'h0);
    chk("full.fetch_ready", {31'b0, bus.fetch_ready}, 32'h0);
    pop(1'b1, 1'b0, 32'h0, 32'h1000);
    chk("full_pop.branch_pc_ex", bus.branch_pc_ex, 32'h1000);
    chk("full_pop.fetch_ready", {31'b0, bus.fetch_ready}, 32'h1);

    // Push and pop together at DEPTH-1 across the pointer wrap
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h1010 + 32'(4 * k), 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0,
            32'h1004 + 32'(4 * k));
      tick();
      chk($sformatf("wrap%0d.branch_ex", k), {31'b0, bus.branch_ex}, 32'h1);
      chk($sformatf("wrap%0d.branch_pc_ex", k), bus.branch_pc_ex, 32'h1004 + 32'(4 * k));
      chk($sformatf("wrap%0d.fetch_ready", k), {31'b0, bus.fetch_ready}, 32'h1);
      chk($sformatf("wrap%0d.branch_cnt", k), {28'b0, bus.branch_cnt}, 32'(2 + k));
    end
    for (int k = 0; k < 3; k++) begin
      pop(1'b1, 1'b0, 32'h0, 32'h102C + 32'(4 * k));
      chk($sformatf("drain%0d.branch_pc_ex", k), bus.branch_pc_ex, 32'h102C + 32'(4 * k));
    end
    chk("wrap.queue_err", {31'b0, bus.queue_err}, 32'h0);
    chk("wrap.branch_cnt", {28'b0, bus.branch_cnt}, 32'd14);

    // Predicted taken, actually not taken: redirect to pc+4
    push(32'h2000, 1'b1, 32'h2100);
    pop(1'b1, 1'b0, 32'h0, 32'h2000);
    chk("dir_nt.flush", {31'b0, bus.flush}, 32'h1);
    chk("dir_nt.redirect_pc", bus.redirect_pc, 32'h2004);
    chk("dir_nt.branch_cnt", {28'b0, bus.branch_cnt}, 32'd15);
    idle();
    chk("dir_nt.flush_width", {31'b0, bus.flush}, 32'h0);

    // branch_cnt saturates
    push(32'h2200, 1'b0, 32'h0);
    pop(1'b1, 1'b0, 32'h0, 32'h2200);
    chk("bsat.branch_ex", {31'b0, bus.branch_ex}, 32'h1);
    chk("bsat.branch_cnt", {28'b0, bus.branch_cnt}, 32'd15);

    // Predicted not taken, actually taken: redirect to actual target
    push(32'h2400, 1'b0, 32'h0);
    pop(1'b1, 1'b1, 32'h2800, 32'h2400);
    chk("dir_t.flush", {31'b0, bus.flush}, 32'h1);
    chk("dir_t.redirect_pc", bus.redirect_pc, 32'h2800);
    chk("dir_t.mispredict_cnt", {28'b0, bus.mispredict_cnt}, 32'd2);
    idle();

    // mispredict_cnt saturates at all-ones
    mexp = 4'd2;
    for (int i = 0; i < 14; i++) begin
      p = 32'h5000 + 32'(16 * i);
      push(p, 1'b1, p + 32'h80);
      pop(1'b0, 1'b0, 32'h0, p);
      mexp = (mexp == 4'hF) ? 4'hF : mexp + 4'd1;
      chk($sformatf("msat%0d.redirect_pc", i), bus.redirect_pc, p + 32'h4);
      chk($sformatf("msat%0d.mispredict_cnt", i), {28'b0, bus.mispredict_cnt}, {28'b0, mexp});
      idle();
    end
    chk("msat.final", {28'b0, bus.mispredict_cnt}, 32'hF);
    chk("msat.queue_err", {31'b0, bus.queue_err}, 32'h0);

    // Head pc mismatch sets queue_err; the update still happens
    push(32'h3100, 1'b0, 32'h0);
    pop(1'b1, 1'b0, 32'h0, 32'h3104);
    chk("pcmm.queue_err", {31'b0, bus.queue_err}, 32'h1);
    chk("pcmm.branch_pc_ex", bus.branch_pc_ex, 32'h3100);

    // Push and pop together on empty: pop is an error, push is kept
    drive(1'b1, 32'h3000, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h3000);
    tick();
    chk("emptypp.branch_ex", {31'b0, bus.branch_ex}, 32'h0);
    chk("emptypp.queue_err", {31'b0, bus.queue_err}, 32'h1);
    pop(1'b1, 1'b0, 32'h0, 32'h3000);
    chk("emptypp.stored_branch_ex", {31'b0, bus.branch_ex}, 32'h1);
    chk("emptypp.stored_pc", bus.branch_pc_ex, 32'h3000);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/branch_resolve.md
# branch_resolve

Branch resolution unit that closes the prediction loop. It records each fetch-stage prediction (taken flag, target) in an in-flight queue, matches it against the actual outcome when the instruction reaches execute, and raises pipeline flush/redirect on a mispredict. It drives the predictor update port (`branch_ex`, `branch_pc_ex`, `branch_taken_ex`, `branch_target_pc`) and keeps branch and mispredict statistics counters. It sits between fetch (producer side) and the ALU/execute stage (consumer side).

## Interface
- `ADDR_WIDTH`, 32, address width
- `DEPTH`, 4, in-flight queue entries (power of 2, ≥2)
- `CNT_WIDTH`, 32, statistics counter width

- `cpu_clk`  in  1  cpu clock
- `cpu_rst`  in  1  cpu reset, asynchronous, active-high
- `fetch_valid`  in  1  fetched instruction pushed this cycle
- `fetch_ready`  out  1  queue can accept a push
- `fetch_pc`  in  ADDR_WIDTH  pc of fetched instruction
- `predict_taken`  in  1  predictor said taken
- `predict_target_pc`  in  ADDR_WIDTH  predicted target
- `ex_valid`  in  1  instruction retiring from execute (pops head)
- `ex_is_branch`  in  1  instruction is a conditional branch or jump
- `ex_taken`  in  1  actual outcome
- `ex_target_pc`  in  ADDR_WIDTH  actual target
- `flush`  out  1  kill younger instructions
- `redirect_pc`  out  ADDR_WIDTH  correct next fetch pc
- `branch_ex`  out  1  predictor update strobe
- `branch_pc_ex`  out  ADDR_WIDTH  pc being updated
- `branch_taken_ex`  out  1  actual outcome for update
- `branch_target_pc`  out  ADDR_WIDTH  actual target for update
- `branch_cnt`  out  CNT_WIDTH  resolved branches
- `mispredict_cnt`  out  CNT_WIDTH  mispredicts
- `queue_err`  out  1  sticky: pop on empty or head pc mismatch

## Operation
- Push: `fetch_valid && fetch_ready` writes {fetch_pc, predict_taken, predict_target_pc} at tail.
- Pop: `ex_valid` with queue non-empty consumes head. Outcome is compared against the head entry.
- Mispredict (evaluated on pop):
  - branch, actual taken ≠ predicted taken → redirect to `ex_target_pc` if taken, else head pc + 4;
  - branch, both taken, target ≠ predicted target → redirect to `ex_target_pc`;
  - non-branch predicted taken (alias) → redirect to head pc + 4.
- Every popped branch (`ex_is_branch`) produces one predictor update with head pc, `ex_taken`, `ex_target_pc`. Aliasing non-branches produce no update.
- On mispredict the queue is cleared. It holds only wrong-path entries.
- Counters: `branch_cnt` increments per popped branch. `mispredict_cnt` increments per mispredict, including aliases. Both saturate at all-ones.
- `queue_err` sets on `ex_valid` with empty queue (pop ignored, no update) or `ex_pc` ≠ head pc. It is cleared only by reset.

## Timing
- All outputs are registered. Reset values: `fetch_ready`=1, `flush`=0, `redirect_pc`=0, `branch_ex`=0, update buses 0, counters 0, `queue_err`=0, queue empty.
- Pop at cycle T produces `branch_ex` and update buses in T+1, one cycle wide. They hold their values otherwise, and the strobe is low.
- Mispredict detected at T:
  - `flush` and `redirect_pc` are valid in T+1, one cycle wide.
  - The queue is empty from T+1.
  - Pushes at T and T+1 are dropped.
  - `ex_valid` at T+1 is ignored.
  - `fetch_ready` is low in T+1.
- `fetch_ready` = not full. It is registered from next-state occupancy, so a push at full is impossible. Simultaneous push and pop at DEPTH-1 keeps occupancy at DEPTH-1. Simultaneous push and pop at DEPTH is not reachable.
- Simultaneous push and pop on an empty queue: the pop sees empty (err path) and the push is stored.
- Pointers are log2(DEPTH)+1 bits; the extra MSB disambiguates full from empty on wrap.
- Asserting reset mid-flush clears everything immediately; `flush` drops asynchronously.

## Structure
- The shared core defines include holds the entry-field widths and the `PC_INCR` (4) constant.
- One sub-module, `bp_inflight_fifo`: a synchronous FIFO with push, pop, clear, full, empty, and a head read. It is parameterised by DEPTH and the entry width.
- Compare logic, the output registers, and the counters stay in `branch_resolve`.

## Test plan
- Reset, then push pc 0x100 (pred NT), pop with branch NT → `branch_ex`=1 at T+1 with pc 0x100 and taken 0, `flush`=0, `branch_cnt`=1.
- Push 0x200 (pred T, target 0x300), pop branch taken target 0x340 → `flush`=1 and `redirect_pc`=0x340 at T+1, queue empty, `mispredict_cnt`=1.
- Push 0x400 (pred T, target 0x500), pop non-branch → `flush`, `redirect_pc`=0x404, `branch_ex`=0, `mispredict_cnt` increments.
- Fill 4 entries → `fetch_ready`=0. Push and pop each cycle for 10 cycles across the wrap → in-order pcs and no err.
- `ex_valid` on empty → `queue_err`=1 (sticky), no update, no counter change. Push during the flush cycle → entry dropped, queue stays empty.
- Preload `mispredict_cnt` to all-ones (CNT_WIDTH=4) and mispredict → the counter stays at 0xF.
